downcounter_timer: RTL and testbench

- Loadable, prescaled down-counting timer. It is the decrementing counterpart to the team's posedge up-counter.
- Counts a loaded value down to zero and flags expiry with a one-cycle pulse.
- Supports one-shot and periodic (auto-reload) modes, plus pause/resume.
- Serves as the delay/timeout collateral for the experiment datapath and control FSMs.

---
 rtl/downcounter_timer_pkg.sv | 11 +
 rtl/ffd_sync_reset.sv | 19 +
 rtl/prescale_tick.sv | 24 ++
 rtl/downcounter_timer.sv | 108 ++++++++++
 tb/tb_downcounter_timer.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/downcounter_timer_pkg.sv
// Shared definitions for the prescaled down-counting timer.
// State encodings are fixed so existing decode logic elsewhere stays valid.
package downcounter_timer_pkg;

   typedef enum logic [1:0] {
      TMR_IDLE  = 2'd0,
      TMR_RUN   = 2'd1,
      TMR_PAUSE = 2'd2
   } tmr_state_e;

endpackage

// File: rtl/ffd_sync_reset.sv
// Positive-edge register with synchronous active-high reset to zero and load enable.
module ffd_sync_reset #(
   parameter int SIZE = 8
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic            Enable,
   input  logic [SIZE-1:0] D,
   output logic [SIZE-1:0] Q
);

   always_ff @(posedge Clock) begin
      if (Reset)
         Q <= '0;
      else if (Enable)
         Q <= D;
   end

endmodule

// File: rtl/prescale_tick.sv
// Prescale divider: Tick fires once every Limit+1 enabled cycles.
module prescale_tick #(
   parameter int PRESCALE_SIZE = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Clear,
   input  logic                     Enable,
   input  logic [PRESCALE_SIZE-1:0] Limit,
   output logic                     Tick
);

   logic [PRESCALE_SIZE-1:0] count;

   assign Tick = Enable && (count == Limit);

   always_ff @(posedge Clock) begin
      if (Reset || Clear)
         count <= '0;
      else if (Enable)
         count <= Tick ? '0 : count + PRESCALE_SIZE'(1);
   end

endmodule

// File: rtl/downcounter_timer.sv
// Loadable down-counting timer with prescaler, one-shot/periodic modes and pause.
module downcounter_timer
   import downcounter_timer_pkg::*;
#(
   parameter int SIZE          = 16,
   parameter int PRESCALE_SIZE = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     Load,
   input  logic [SIZE-1:0]          LoadValue,
   input  logic [PRESCALE_SIZE-1:0] Prescale,
   input  logic                     Periodic,
   input  logic                     Start,
   input  logic                     Stop,
   output logic [SIZE-1:0]          Q,
   output logic                     Running,
   output logic                     Expired
);

   tmr_state_e               state, state_nx;
   logic [SIZE-1:0]          reload;
   logic [PRESCALE_SIZE-1:0] prescale_reg;
   logic [SIZE-1:0]          q_nx;
   logic                     expired_nx;
   logic                     tick;

   ffd_sync_reset #(.SIZE(SIZE)) u_reload (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (Load),
      .D      (LoadValue),
      .Q      (reload)
   );

   ffd_sync_reset #(.SIZE(PRESCALE_SIZE)) u_prescale (
      .Clock  (Clock),
      .Reset  (Reset),
      .Enable (Load),
      .D      (Prescale),
      .Q      (prescale_reg)
   );

   // Stop freezes the divider in the same edge it pauses the count.
   prescale_tick #(.PRESCALE_SIZE(PRESCALE_SIZE)) u_tick (
      .Clock  (Clock),
      .Reset  (Reset),
      .Clear  (Load),
      .Enable ((state == TMR_RUN) && !Stop && !Load),
      .Limit  (prescale_reg),
      .Tick   (tick)
   );

   always_comb begin
      state_nx   = state;
      q_nx       = Q;
      expired_nx = 1'b0;
      if (Load) begin
         state_nx = TMR_IDLE;
         q_nx     = LoadValue;
      end else begin
         case (state)
            TMR_RUN: begin
               if (Stop)
                  state_nx = TMR_PAUSE;
               else if (tick) begin
                  if (Q > SIZE'(1))
                     q_nx = Q - SIZE'(1);
                  else begin
                     expired_nx = 1'b1;
                     if (Periodic)
                        q_nx = reload;
                     else begin
                        q_nx     = '0;
                        state_nx = TMR_IDLE;
                     end
                  end
               end
            end
            TMR_PAUSE: begin
               if (!Stop && Start && (Q != '0))
                  state_nx = TMR_RUN;
            end
            default: begin
               if (!Stop && Start && (Q != '0))
                  state_nx = TMR_RUN;
               else
                  state_nx = TMR_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= TMR_IDLE;
         Q       <= '0;
         Expired <= 1'b0;
      end else begin
         state   <= state_nx;
         Q       <= q_nx;
         Expired <= expired_nx;
      end
   end

   assign Running = (state == TMR_RUN);

endmodule

// File: tb/tb_downcounter_timer.sv
// Directed self-checking bench for downcounter_timer: vector table plus multi-cycle sequences.
module tb_downcounter_timer;

   localparam int SIZE = 16;
   localparam int PS   = 8;

   logic            Clock = 1'b0;
   logic            Reset, Load, Periodic, Start, Stop;
   logic [SIZE-1:0] LoadValue;
   logic [PS-1:0]   Prescale;
   logic [SIZE-1:0] Q;
   logic            Running, Expired;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string           name;
      logic            rst, ld;
      logic [SIZE-1:0] lv;
      logic [PS-1:0]   ps;
      logic            per, st, sp;
      logic [SIZE-1:0] eq;
      logic            er, ee;
   } vec_t;

   vec_t vecs[$];

   always #5 Clock = ~Clock;

   downcounter_timer #(.SIZE(SIZE), .PRESCALE_SIZE(PS)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Load      (Load),
      .LoadValue (LoadValue),
      .Prescale  (Prescale),
      .Periodic  (Periodic),
      .Start     (Start),
      .Stop      (Stop),
      .Q         (Q),
      .Running   (Running),
      .Expired   (Expired)
   );

   task automatic check(input string name, input logic [SIZE-1:0] q_req,
                        input logic r_req, input logic e_req);
      total++;
      if (Q !== q_req || Running !== r_req || Expired !== e_req) begin
         bad++;
         $display("FAIL %s: got Q=%0d Running=%b Expired=%b, want Q=%0d Running=%b Expired=%b",
                  name, Q, Running, Expired, q_req, r_req, e_req);
      end
   endtask

   task automatic drive(input logic rst, ld, input logic [SIZE-1:0] lv,
                        input logic [PS-1:0] ps, input logic per, st, sp);
      Reset = rst; Load = ld; LoadValue = lv; Prescale = ps;
      Periodic = per; Start = st; Stop = sp;
      @(posedge Clock);
      #1;
   endtask

   task automatic add(input string name, input logic rst, ld, input logic [SIZE-1:0] lv,
                      input logic [PS-1:0] ps, input logic per, st, sp,
                      input logic [SIZE-1:0] eq, input logic er, ee);
      vec_t v;
      v.name = name; v.rst = rst; v.ld = ld; v.lv = lv; v.ps = ps;
      v.per = per; v.st = st; v.sp = sp; v.eq = eq; v.er = er; v.ee = ee;
      vecs.push_back(v);
   endtask

   task automatic run_table();
      vec_t v;
      while (vecs.size() > 0) begin
         v = vecs.pop_front();
         drive(v.rst, v.ld, v.lv, v.ps, v.per, v.st, v.sp);
         check(v.name, v.eq, v.er, v.ee);
      end
   endtask

   initial begin
      logic [SIZE-1:0] mq;
      logic            me;
      Reset = 1'b1; Load = 1'b0; LoadValue = '0; Prescale = '0;
      Periodic = 1'b0; Start = 1'b0; Stop = 1'b0;
      #1;

      //      name          rst ld lv ps per st sp   Q  R  E
      add("reset_prio",     1, 1, 9, 0, 0, 1, 0,   0, 0, 0);
      add("start_q0",       0, 0, 0, 0, 0, 1, 0,   0, 0, 0);
      add("start_q0_hold",  0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
      add("os_load3",       0, 1, 3, 0, 0, 0, 0,   3, 0, 0);
      add("os_start",       0, 0, 0, 0, 0, 1, 0,   3, 1, 0);
      add("os_e1_restart",  0, 0, 0, 0, 0, 1, 0,   2, 1, 0);
      add("os_e2",          0, 0, 0, 0, 0, 0, 0,   1, 1, 0);
      add("os_e3_expire",   0, 0, 0, 0, 0, 0, 0,   0, 0, 1);
      add("os_after",       0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
      add("ps_load5",       0, 1, 5, 0, 0, 0, 0,   5, 0, 0);
      add("ps_start",       0, 0, 0, 0, 0, 1, 0,   5, 1, 0);
      add("ps_e1",          0, 0, 0, 0, 0, 0, 0,   4, 1, 0);
      add("ps_e2",          0, 0, 0, 0, 0, 0, 0,   3, 1, 0);
      add("ps_stop",        0, 0, 0, 0, 0, 0, 1,   3, 0, 0);
      run_table();

      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0);
         check("pause_hold", 3, 0, 0);
      end

      add("resume",         0, 0, 0, 0, 0, 1, 0,   3, 1, 0);
      add("resume_e1",      0, 0, 0, 0, 0, 0, 0,   2, 1, 0);
      add("resume_e2",      0, 0, 0, 0, 0, 0, 0,   1, 1, 0);
      add("resume_expire",  0, 0, 0, 0, 0, 0, 0,   0, 0, 1);
      add("pp_load6",       0, 1, 6, 0, 0, 0, 0,   6, 0, 0);
      add("pp_start",       0, 0, 0, 0, 0, 1, 0,   6, 1, 0);
      add("pp_e1",          0, 0, 0, 0, 0, 0, 0,   5, 1, 0);
      add("pp_stop",        0, 0, 0, 0, 0, 0, 1,   5, 0, 0);
      add("pp_start_stop",  0, 0, 0, 0, 0, 1, 1,   5, 0, 0);
      add("pp_resume",      0, 0, 0, 0, 0, 1, 0,   5, 1, 0);
      add("pp_e2",          0, 0, 0, 0, 0, 0, 0,   4, 1, 0);
      add("abort_load7",    0, 1, 7, 0, 0, 0, 0,   7, 0, 0);
      add("abort_idle",     0, 0, 0, 0, 0, 0, 0,   7, 0, 0);
      add("p1_load1",       0, 1, 1, 0, 1, 0, 0,   1, 0, 0);
      add("p1_start",       0, 0, 0, 0, 1, 1, 0,   1, 1, 0);
      add("p1_e1",          0, 0, 0, 0, 1, 0, 0,   1, 1, 1);
      add("p1_e2",          0, 0, 0, 0, 1, 0, 0,   1, 1, 1);
      add("p1_e3",          0, 0, 0, 0, 1, 0, 0,   1, 1, 1);
      add("p1_last",        0, 0, 0, 0, 0, 0, 0,   0, 0, 1);
      add("p1_idle",        0, 0, 0, 0, 0, 0, 0,   0, 0, 0);
      add("rm_load5",       0, 1, 5, 0, 0, 0, 0,   5, 0, 0);
      add("rm_start",       0, 0, 0, 0, 0, 1, 0,   5, 1, 0);
      add("rm_e1",          0, 0, 0, 0, 0, 0, 0,   4, 1, 0);
      add("rm_reset",       1, 0, 0, 0, 0, 0, 0,   0, 0, 0);
      add("per_load2",      0, 1, 2, 3, 1, 0, 0,   2, 0, 0);
      add("per_start",      0, 0, 0, 0, 1, 1, 0,   2, 1, 0);
      run_table();

      // Periodic reload 2 with Prescale 3: tick every 4th edge, expiry every 8.
      mq = 2;
      me = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         drive(0, 0, 0, 0, 1, 0, 0);
         me = 1'b0;
         if (k % 4 == 0) begin
            if (mq == 1) begin
               mq = 2;
               me = 1'b1;
            end else
               mq = mq - 1;
         end
         check("periodic_ps3", mq, 1'b1, me);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
